mem_channel_arbiter: RTL and testbench
======================================

# mem_channel_arbiter

Shares one DDR channel's command/data/status streams, on the memory-interface side, between two requesters: requester 0 is the TCP/IP stack and requester 1 is the user role. Read and write commands are arbitrated independently with round-robin. Every grant records the requester ID in order-tracking FIFOs. Read data, read status and write status returning from the memory interface are steered back to the owning requester in issue order. Write data is locked to the requester whose write command was granted.

## Interface
- ADDR_W, 64, command address width
- LEN_W, 32, command length width (bytes)
- DATA_W, 512, data bus width; KEEP_W = DATA_W/8
- STS_W, 8, status word width
- MAX_OUTSTANDING, 16, depth of each ID FIFO (power of 2)

Ports (requester-side vectors: bit/slice 0 = TCP, 1 = role):
- net_clk  in  1  sole clock
- net_aresetn  in  1  asynchronous active-low reset
- s_rd_cmd_valid / s_rd_cmd_ready  in/out  2  per-requester read command handshake
- s_rd_cmd_addr / s_rd_cmd_len  in  2*ADDR_W / 2*LEN_W  per-requester read command fields
- s_wr_cmd_valid / _ready / _addr / _len  same widths  per-requester write command
- m_rd_cmd_valid / m_rd_cmd_ready  out/in  1  arbitrated read command to memory
- m_rd_cmd_addr / m_rd_cmd_len  out  ADDR_W / LEN_W  arbitrated read fields
- m_wr_cmd_valid / _ready / _addr / _len  same  arbitrated write command
- s_mem_rd_data_valid / _ready / _data / _keep / _last  in/out/in/in/in  1/1/DATA_W/KEEP_W/1  read data from memory
- m_rd_data_valid / m_rd_data_ready  out/in  2  per-requester read data handshake
- m_rd_data_data / _keep / _last  out  DATA_W/KEEP_W/1  read data broadcast to both requesters
- s_wr_data_valid / _ready / _last  in/out/in  2  per-requester write data handshake
- s_wr_data_data / _keep  in  2*DATA_W / 2*KEEP_W  per-requester write payload
- m_mem_wr_data_valid / _ready / _data / _keep / _last  out/in/out/out/out  write data to memory
- s_mem_rd_sts_valid / _ready / _data  in/out/in  1/1/STS_W  read status from memory
- m_rd_sts_valid / m_rd_sts_ready  out/in  2; m_rd_sts_data  out  STS_W  routed read status
- s_mem_wr_sts_* / m_wr_sts_*  same shape  write status

## Operation
- Command stage (read and write identical, independent): registered output slot. The slot loads when it is empty or m_*_cmd_ready=1, and the command's ID FIFO(s) are not full.
- Grant: when both requesters are valid, the one indicated by a priority pointer wins. After every grant the pointer moves to the other requester. The pointer resets to 0.
- s_*_cmd_ready is 1 only for the granted requester, only in its load cycle.
- On a read grant: push the ID into rd_data_fifo and rd_sts_fifo.
- On a write grant: push the ID into wr_sts_fifo. The write FSM must also be able to accept a burst.
- Write FSM states:
  - W_IDLE: write grant allowed. Grant -> W_DATA, owner := ID.
  - W_DATA: no further write grants. The owner's s_wr_data is muxed to the memory port and ready is passed back to the owner only. Last-beat handshake -> W_IDLE.
- Read data: routed combinationally to the ID at the head of rd_data_fifo.
  - s_mem_rd_data_ready = head requester's ready AND FIFO non-empty.
  - Pop on last-beat handshake.
  - Data arriving while the FIFO is empty is stalled (ready=0), never dropped.
- Status (read and write): same routing from the head of the respective FIFO. Pop on status handshake.
- The non-owner valid is always 0.

## Timing
- Reset values: all *_valid and *_ready outputs 0, slots empty, FIFOs empty, pointer 0, FSM W_IDLE.
- Command latency: s_valid to m_valid is 1 cycle. Back-to-back grants are allowed every cycle while m_ready=1 (reads). Writes are limited to one burst in flight.
- Data and status paths add 0 cycles (combinational mux). Valid and ready never depend on each other within the same requester's path beyond the mux.
- A granted command is held stable in the slot until m_ready.
- ID FIFO full (MAX_OUTSTANDING entries) blocks new grants of that type. A push and a pop in the same cycle on a full FIFO must still be accepted.
- A simultaneous pop and push on an empty FIFO is allowed. A response cannot use an ID pushed in the same cycle.
- An asynchronous reset mid-burst aborts everything immediately. Outstanding responses are discarded by design; upstream must be reset together.

## Test plan
- Both requesters assert read valid every cycle, m_rd_cmd_ready=1 -> grants alternate 0,1,0,1; m_rd_cmd_addr matches the source each cycle.
- TCP read (len 128) then role read (len 64); memory returns 2+1 beats -> beats 0-1 appear on m_rd_data_valid[0], beat 2 on [1]; read status words go to [0] then [1].
- Role write granted, 4-beat burst; TCP write valid during the burst -> TCP s_wr_cmd_ready stays 0 until role last beat; TCP granted the cycle after.
- 16 reads issued with no responses -> 17th stalls with s_rd_cmd_ready=0; one read status plus last data beat returned -> 17th granted next cycle.
- Memory read data valid with FIFO empty -> s_mem_rd_data_ready=0; m_rd_data_valid=2'b00.
- Assert net_aresetn=0 mid write burst -> all outputs 0 immediately; after release, the pointer favours TCP on the first contention.

Source files
------------

// File: rtl/mem_channel_arbiter_if.sv
// Every stream between the two requesters (TCP = 0, role = 1), the arbiter and one DDR channel.
// The slave modport is the arbiter's view; master is the surrounding fabric's view.
interface mem_channel_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32,
    parameter int DATA_W = 512,
    parameter int STS_W  = 8
);
    localparam int KEEP_W = DATA_W / 8;

    logic [1:0]          s_rd_cmd_valid;
    logic [1:0]          s_rd_cmd_ready;
    logic [2*ADDR_W-1:0] s_rd_cmd_addr;
    logic [2*LEN_W-1:0]  s_rd_cmd_len;
    logic [1:0]          s_wr_cmd_valid;
    logic [1:0]          s_wr_cmd_ready;
    logic [2*ADDR_W-1:0] s_wr_cmd_addr;
    logic [2*LEN_W-1:0]  s_wr_cmd_len;

    logic                m_rd_cmd_valid;
    logic                m_rd_cmd_ready;
    logic [ADDR_W-1:0]   m_rd_cmd_addr;
    logic [LEN_W-1:0]    m_rd_cmd_len;
    logic                m_wr_cmd_valid;
    logic                m_wr_cmd_ready;
    logic [ADDR_W-1:0]   m_wr_cmd_addr;
    logic [LEN_W-1:0]    m_wr_cmd_len;

    logic                s_mem_rd_data_valid;
    logic                s_mem_rd_data_ready;
    logic [DATA_W-1:0]   s_mem_rd_data_data;
    logic [KEEP_W-1:0]   s_mem_rd_data_keep;
    logic                s_mem_rd_data_last;
    logic [1:0]          m_rd_data_valid;
    logic [1:0]          m_rd_data_ready;
    logic [DATA_W-1:0]   m_rd_data_data;
    logic [KEEP_W-1:0]   m_rd_data_keep;
    logic                m_rd_data_last;

    logic [1:0]          s_wr_data_valid;
    logic [1:0]          s_wr_data_ready;
    logic [1:0]          s_wr_data_last;
    logic [2*DATA_W-1:0] s_wr_data_data;
    logic [2*KEEP_W-1:0] s_wr_data_keep;
    logic                m_mem_wr_data_valid;
    logic                m_mem_wr_data_ready;
    logic [DATA_W-1:0]   m_mem_wr_data_data;
    logic [KEEP_W-1:0]   m_mem_wr_data_keep;
    logic                m_mem_wr_data_last;

    logic                s_mem_rd_sts_valid;
    logic                s_mem_rd_sts_ready;
    logic [STS_W-1:0]    s_mem_rd_sts_data;
    logic [1:0]          m_rd_sts_valid;
    logic [1:0]          m_rd_sts_ready;
    logic [STS_W-1:0]    m_rd_sts_data;
    logic                s_mem_wr_sts_valid;
    logic                s_mem_wr_sts_ready;
    logic [STS_W-1:0]    s_mem_wr_sts_data;
    logic [1:0]          m_wr_sts_valid;
    logic [1:0]          m_wr_sts_ready;
    logic [STS_W-1:0]    m_wr_sts_data;

    modport slave (
        input  s_rd_cmd_valid, s_rd_cmd_addr, s_rd_cmd_len,
        output s_rd_cmd_ready,
        input  s_wr_cmd_valid, s_wr_cmd_addr, s_wr_cmd_len,
        output s_wr_cmd_ready,
        output m_rd_cmd_valid, m_rd_cmd_addr, m_rd_cmd_len,
        input  m_rd_cmd_ready,
        output m_wr_cmd_valid, m_wr_cmd_addr, m_wr_cmd_len,
        input  m_wr_cmd_ready,
        input  s_mem_rd_data_valid, s_mem_rd_data_data, s_mem_rd_data_keep, s_mem_rd_data_last,
        output s_mem_rd_data_ready,
        output m_rd_data_valid, m_rd_data_data, m_rd_data_keep, m_rd_data_last,
        input  m_rd_data_ready,
        input  s_wr_data_valid, s_wr_data_last, s_wr_data_data, s_wr_data_keep,
        output s_wr_data_ready,
        output m_mem_wr_data_valid, m_mem_wr_data_data, m_mem_wr_data_keep, m_mem_wr_data_last,
        input  m_mem_wr_data_ready,
        input  s_mem_rd_sts_valid, s_mem_rd_sts_data,
        output s_mem_rd_sts_ready,
        output m_rd_sts_valid, m_rd_sts_data,
        input  m_rd_sts_ready,
        input  s_mem_wr_sts_valid, s_mem_wr_sts_data,
        output s_mem_wr_sts_ready,
        output m_wr_sts_valid, m_wr_sts_data,
        input  m_wr_sts_ready
    );

    modport master (
        output s_rd_cmd_valid, s_rd_cmd_addr, s_rd_cmd_len,
        input  s_rd_cmd_ready,
        output s_wr_cmd_valid, s_wr_cmd_addr, s_wr_cmd_len,
        input  s_wr_cmd_ready,
        input  m_rd_cmd_valid, m_rd_cmd_addr, m_rd_cmd_len,
        output m_rd_cmd_ready,
        input  m_wr_cmd_valid, m_wr_cmd_addr, m_wr_cmd_len,
        output m_wr_cmd_ready,
        output s_mem_rd_data_valid, s_mem_rd_data_data, s_mem_rd_data_keep, s_mem_rd_data_last,
        input  s_mem_rd_data_ready,
        input  m_rd_data_valid, m_rd_data_data, m_rd_data_keep, m_rd_data_last,
        output m_rd_data_ready,
        output s_wr_data_valid, s_wr_data_last, s_wr_data_data, s_wr_data_keep,
        input  s_wr_data_ready,
        input  m_mem_wr_data_valid, m_mem_wr_data_data, m_mem_wr_data_keep, m_mem_wr_data_last,
        output m_mem_wr_data_ready,
        output s_mem_rd_sts_valid, s_mem_rd_sts_data,
        input  s_mem_rd_sts_ready,
        input  m_rd_sts_valid, m_rd_sts_data,
        output m_rd_sts_ready,
        output s_mem_wr_sts_valid, s_mem_wr_sts_data,
        input  s_mem_wr_sts_ready,
        input  m_wr_sts_valid, m_wr_sts_data,
        output m_wr_sts_ready
    );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Two-requester arbiter for one DDR channel: round-robin command grants, ID FIFOs that
// steer responses back in issue order, and a write-data lock held for one burst.
module mem_channel_arbiter_id_fifo #(
    parameter int DEPTH = 16
) (
    input  logic net_clk,
    input  logic net_aresetn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head_id
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        id_mem [DEPTH];
    logic        push_en;
    logic        pop_en;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_en  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign head_id = id_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge net_clk) begin
        if (push_en) begin
            id_mem[wr_ptr_reg[AW-1:0]] <= push_id;
        end
    end

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end
endmodule

module mem_channel_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int LEN_W           = 32,
    parameter int DATA_W          = 512,
    parameter int STS_W           = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                  net_clk,
    input  logic                  net_aresetn,
    mem_channel_arbiter_if.slave  bus
);
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {W_IDLE = 1'b0, W_DATA = 1'b1} w_state_t;

    logic rd_data_full, rd_data_empty, rd_data_head, rd_data_pop;
    logic rd_sts_full,  rd_sts_empty,  rd_sts_head,  rd_sts_pop;
    logic wr_sts_full,  wr_sts_empty,  wr_sts_head,  wr_sts_pop;

    // ---------------- read command slot ----------------
    logic              rd_slot_valid_reg;
    logic [ADDR_W-1:0] rd_slot_addr_reg;
    logic [LEN_W-1:0]  rd_slot_len_reg;
    logic              rd_prio_reg;
    logic              rd_winner, rd_room, rd_grant;

    assign rd_winner = (&bus.s_rd_cmd_valid) ? rd_prio_reg : bus.s_rd_cmd_valid[1];
    assign rd_room   = (!rd_data_full || rd_data_pop) && (!rd_sts_full || rd_sts_pop);
    // Gating with the reset keeps every ready low while the block is held in reset.
    assign rd_grant  = net_aresetn && (|bus.s_rd_cmd_valid) && rd_room &&
                       (!rd_slot_valid_reg || bus.m_rd_cmd_ready);
    assign bus.s_rd_cmd_ready = rd_grant ? (rd_winner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            rd_slot_valid_reg <= 1'b0;
            rd_slot_addr_reg  <= '0;
            rd_slot_len_reg   <= '0;
            rd_prio_reg       <= 1'b0;
        end else if (rd_grant) begin
            rd_slot_valid_reg <= 1'b1;
            rd_slot_addr_reg  <= rd_winner ? bus.s_rd_cmd_addr[2*ADDR_W-1:ADDR_W]
                                           : bus.s_rd_cmd_addr[ADDR_W-1:0];
            rd_slot_len_reg   <= rd_winner ? bus.s_rd_cmd_len[2*LEN_W-1:LEN_W]
                                           : bus.s_rd_cmd_len[LEN_W-1:0];
            rd_prio_reg       <= ~rd_winner;
        end else if (bus.m_rd_cmd_ready) begin
            rd_slot_valid_reg <= 1'b0;
        end
    end

    assign bus.m_rd_cmd_valid = rd_slot_valid_reg;
    assign bus.m_rd_cmd_addr  = rd_slot_addr_reg;
    assign bus.m_rd_cmd_len   = rd_slot_len_reg;

    // ---------------- write command slot ----------------
    logic              wr_slot_valid_reg;
    logic [ADDR_W-1:0] wr_slot_addr_reg;
    logic [LEN_W-1:0]  wr_slot_len_reg;
    logic              wr_prio_reg;
    logic              wr_winner, wr_grant;
    w_state_t          w_state_reg, w_state_next;
    logic              w_owner_reg, w_owner_next;

    assign wr_winner = (&bus.s_wr_cmd_valid) ? wr_prio_reg : bus.s_wr_cmd_valid[1];
    assign wr_grant  = net_aresetn && (|bus.s_wr_cmd_valid) && (w_state_reg == W_IDLE) &&
                       (!wr_sts_full || wr_sts_pop) &&
                       (!wr_slot_valid_reg || bus.m_wr_cmd_ready);
    assign bus.s_wr_cmd_ready = wr_grant ? (wr_winner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            wr_slot_valid_reg <= 1'b0;
            wr_slot_addr_reg  <= '0;
            wr_slot_len_reg   <= '0;
            wr_prio_reg       <= 1'b0;
        end else if (wr_grant) begin
            wr_slot_valid_reg <= 1'b1;
            wr_slot_addr_reg  <= wr_winner ? bus.s_wr_cmd_addr[2*ADDR_W-1:ADDR_W]
                                           : bus.s_wr_cmd_addr[ADDR_W-1:0];
            wr_slot_len_reg   <= wr_winner ? bus.s_wr_cmd_len[2*LEN_W-1:LEN_W]
                                           : bus.s_wr_cmd_len[LEN_W-1:0];
            wr_prio_reg       <= ~wr_winner;
        end else if (bus.m_wr_cmd_ready) begin
            wr_slot_valid_reg <= 1'b0;
        end
    end

    assign bus.m_wr_cmd_valid = wr_slot_valid_reg;
    assign bus.m_wr_cmd_addr  = wr_slot_addr_reg;
    assign bus.m_wr_cmd_len   = wr_slot_len_reg;

    // ---------------- write data lock ----------------
    logic              wr_data_valid, wr_data_last;
    logic [DATA_W-1:0] wr_data_data;
    logic [KEEP_W-1:0] wr_data_keep;
    logic [1:0]        wr_data_ready_vec;

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            w_state_reg <= W_IDLE;
            w_owner_reg <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            w_owner_reg <= w_owner_next;
        end
    end

    always_comb begin
        w_state_next      = w_state_reg;
        w_owner_next      = w_owner_reg;
        wr_data_valid     = 1'b0;
        wr_data_last      = 1'b0;
        wr_data_data      = '0;
        wr_data_keep      = '0;
        wr_data_ready_vec = 2'b00;
        case (w_state_reg)
            W_IDLE: begin
                if (wr_grant) begin
                    w_state_next = W_DATA;
                    w_owner_next = wr_winner;
                end
            end
            W_DATA: begin
                wr_data_valid = bus.s_wr_data_valid[w_owner_reg];
                wr_data_last  = bus.s_wr_data_last[w_owner_reg];
                wr_data_data  = w_owner_reg ? bus.s_wr_data_data[2*DATA_W-1:DATA_W]
                                            : bus.s_wr_data_data[DATA_W-1:0];
                wr_data_keep  = w_owner_reg ? bus.s_wr_data_keep[2*KEEP_W-1:KEEP_W]
                                            : bus.s_wr_data_keep[KEEP_W-1:0];
                wr_data_ready_vec[w_owner_reg] = bus.m_mem_wr_data_ready;
                if (wr_data_valid && bus.m_mem_wr_data_ready && wr_data_last) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign bus.m_mem_wr_data_valid = wr_data_valid;
    assign bus.m_mem_wr_data_last  = wr_data_last;
    assign bus.m_mem_wr_data_data  = wr_data_data;
    assign bus.m_mem_wr_data_keep  = wr_data_keep;
    assign bus.s_wr_data_ready     = wr_data_ready_vec;

    // ---------------- ID FIFOs ----------------
    mem_channel_arbiter_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rd_data_fifo (
        .net_clk(net_clk), .net_aresetn(net_aresetn), .push(rd_grant), .push_id(rd_winner),
        .pop(rd_data_pop), .full(rd_data_full), .empty(rd_data_empty), .head_id(rd_data_head));
    mem_channel_arbiter_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rd_sts_fifo (
        .net_clk(net_clk), .net_aresetn(net_aresetn), .push(rd_grant), .push_id(rd_winner),
        .pop(rd_sts_pop), .full(rd_sts_full), .empty(rd_sts_empty), .head_id(rd_sts_head));
    mem_channel_arbiter_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_wr_sts_fifo (
        .net_clk(net_clk), .net_aresetn(net_aresetn), .push(wr_grant), .push_id(wr_winner),
        .pop(wr_sts_pop), .full(wr_sts_full), .empty(wr_sts_empty), .head_id(wr_sts_head));

    // ---------------- response steering ----------------
    logic             rd_data_avail, rd_sts_avail, wr_sts_avail;
    logic [1:0]       rd_data_valid_vec, rd_sts_valid_vec, wr_sts_valid_vec;
    logic [STS_W-1:0] rd_sts_word, wr_sts_word;

    // Responses with no owner on record are held off, never dropped.
    assign rd_data_avail = bus.s_mem_rd_data_valid && !rd_data_empty;
    assign rd_sts_avail  = bus.s_mem_rd_sts_valid  && !rd_sts_empty;
    assign wr_sts_avail  = bus.s_mem_wr_sts_valid  && !wr_sts_empty;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            assign rd_data_valid_vec[gi] = rd_data_avail && (rd_data_head == (gi == 1));
            assign rd_sts_valid_vec[gi]  = rd_sts_avail  && (rd_sts_head  == (gi == 1));
            assign wr_sts_valid_vec[gi]  = wr_sts_avail  && (wr_sts_head  == (gi == 1));
        end
    endgenerate

    assign bus.m_rd_data_valid     = rd_data_valid_vec;
    assign bus.m_rd_data_data      = bus.s_mem_rd_data_data;
    assign bus.m_rd_data_keep      = bus.s_mem_rd_data_keep;
    assign bus.m_rd_data_last      = bus.s_mem_rd_data_last;
    assign bus.s_mem_rd_data_ready = bus.m_rd_data_ready[rd_data_head] && !rd_data_empty;
    assign rd_data_pop = bus.s_mem_rd_data_valid && bus.s_mem_rd_data_ready &&
                         bus.s_mem_rd_data_last;

    assign rd_sts_word            = bus.s_mem_rd_sts_data;
    assign bus.m_rd_sts_data      = rd_sts_word;
    assign bus.m_rd_sts_valid     = rd_sts_valid_vec;
    assign bus.s_mem_rd_sts_ready = bus.m_rd_sts_ready[rd_sts_head] && !rd_sts_empty;
    assign rd_sts_pop = bus.s_mem_rd_sts_valid && bus.s_mem_rd_sts_ready;

    assign wr_sts_word            = bus.s_mem_wr_sts_data;
    assign bus.m_wr_sts_data      = wr_sts_word;
    assign bus.m_wr_sts_valid     = wr_sts_valid_vec;
    assign bus.s_mem_wr_sts_ready = bus.m_wr_sts_ready[wr_sts_head] && !wr_sts_empty;
    assign wr_sts_pop = bus.s_mem_wr_sts_valid && bus.s_mem_wr_sts_ready;
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: arbitration, response steering, write lock,
// FIFO-full back-pressure, empty-FIFO stall and asynchronous reset.
module tb_mem_channel_arbiter;
    localparam int ADDR_W = 64;
    localparam int LEN_W  = 32;
    localparam int DATA_W = 512;
    localparam int STS_W  = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_channel_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .STS_W(STS_W)) bus ();

    mem_channel_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .STS_W(STS_W),
                          .MAX_OUTSTANDING(16)) dut (
        .net_clk(clk),
        .net_aresetn(rst_n),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.s_rd_cmd_valid = '0; bus.s_rd_cmd_addr = '0; bus.s_rd_cmd_len = '0;
        bus.s_wr_cmd_valid = '0; bus.s_wr_cmd_addr = '0; bus.s_wr_cmd_len = '0;
        bus.m_rd_cmd_ready = 1'b0; bus.m_wr_cmd_ready = 1'b0;
        bus.s_mem_rd_data_valid = 1'b0; bus.s_mem_rd_data_data = '0;
        bus.s_mem_rd_data_keep = '0; bus.s_mem_rd_data_last = 1'b0;
        bus.m_rd_data_ready = '0;
        bus.s_wr_data_valid = '0; bus.s_wr_data_last = '0;
        bus.s_wr_data_data = '0; bus.s_wr_data_keep = '0;
        bus.m_mem_wr_data_ready = 1'b0;
        bus.s_mem_rd_sts_valid = 1'b0; bus.s_mem_rd_sts_data = '0; bus.m_rd_sts_ready = '0;
        bus.s_mem_wr_sts_valid = 1'b0; bus.s_mem_wr_sts_data = '0; bus.m_wr_sts_ready = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        bus.s_rd_cmd_valid = 2'b11; bus.s_wr_cmd_valid = 2'b11;
        bus.m_rd_cmd_ready = 1'b1;  bus.m_wr_cmd_ready = 1'b1;
        bus.s_mem_rd_data_valid = 1'b1; bus.m_rd_data_ready = 2'b11;
        bus.s_mem_rd_sts_valid = 1'b1;  bus.m_rd_sts_ready = 2'b11;
        bus.s_mem_wr_sts_valid = 1'b1;  bus.m_wr_sts_ready = 2'b11;
        bus.s_wr_data_valid = 2'b11;    bus.m_mem_wr_data_ready = 1'b1;
        tick();
        n_checks++;
        if ({bus.s_rd_cmd_ready, bus.s_wr_cmd_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b required 0000", {bus.s_rd_cmd_ready, bus.s_wr_cmd_ready});
        end
        n_checks++;
        if ({bus.m_rd_cmd_valid, bus.m_wr_cmd_valid, bus.m_mem_wr_data_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mem_valid: got %b required 000",
                     {bus.m_rd_cmd_valid, bus.m_wr_cmd_valid, bus.m_mem_wr_data_valid});
        end
        n_checks++;
        if ({bus.m_rd_data_valid, bus.m_rd_sts_valid, bus.m_wr_sts_valid, bus.s_wr_data_ready} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_req_side: got %b required 00000000",
                     {bus.m_rd_data_valid, bus.m_rd_sts_valid, bus.m_wr_sts_valid, bus.s_wr_data_ready});
        end
        n_checks++;
        if ({bus.s_mem_rd_data_ready, bus.s_mem_rd_sts_ready, bus.s_mem_wr_sts_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mem_ready: got %b required 000",
                     {bus.s_mem_rd_data_ready, bus.s_mem_rd_sts_ready, bus.s_mem_wr_sts_ready});
        end
        $display("reset: outputs sampled while net_aresetn low");
    endtask

    task automatic test_round_robin();
        logic [1:0]        exp_rdy;
        logic [ADDR_W-1:0] exp_addr;
        do_reset();
        bus.m_rd_cmd_ready = 1'b1;
        bus.s_rd_cmd_valid = 2'b11;
        bus.s_rd_cmd_addr  = {64'h0000_0000_0000_2000, 64'h0000_0000_0000_1000};
        for (int i = 0; i < 4; i++) begin
            exp_rdy  = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_addr = (i % 2 == 1) ? 64'h2000 : 64'h1000;
            #1;
            n_checks++;
            if (bus.s_rd_cmd_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %b required %b", i, bus.s_rd_cmd_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (bus.m_rd_cmd_valid !== 1'b1 || bus.m_rd_cmd_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL rr_addr[%0d]: got valid %b addr %h required 1 %h",
                         i, bus.m_rd_cmd_valid, bus.m_rd_cmd_addr, exp_addr);
            end
            $display("rr read grant %0d addr %h", i, bus.m_rd_cmd_addr);
        end
        bus.s_rd_cmd_valid = 2'b00;
    endtask

    task automatic test_read_routing();
        logic [DATA_W-1:0] d;
        do_reset();
        bus.m_rd_cmd_ready = 1'b1;
        bus.s_rd_cmd_valid = 2'b01;
        bus.s_rd_cmd_addr[ADDR_W-1:0] = 64'h100;
        bus.s_rd_cmd_len[LEN_W-1:0]   = 32'd128;
        tick();
        n_checks++;
        if (bus.m_rd_cmd_addr !== 64'h100 || bus.m_rd_cmd_len !== 32'd128) begin
            n_fail++;
            $display("FAIL route_cmd_tcp: got %h/%0d required 100/128", bus.m_rd_cmd_addr, bus.m_rd_cmd_len);
        end
        bus.s_rd_cmd_valid = 2'b10;
        bus.s_rd_cmd_addr[2*ADDR_W-1:ADDR_W] = 64'h200;
        bus.s_rd_cmd_len[2*LEN_W-1:LEN_W]    = 32'd64;
        tick();
        n_checks++;
        if (bus.m_rd_cmd_addr !== 64'h200 || bus.m_rd_cmd_len !== 32'd64) begin
            n_fail++;
            $display("FAIL route_cmd_role: got %h/%0d required 200/64", bus.m_rd_cmd_addr, bus.m_rd_cmd_len);
        end
        bus.s_rd_cmd_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            d = {8{64'hD000_0000_0000_0000 + 64'(k)}};
            bus.s_mem_rd_data_valid = 1'b1;
            bus.s_mem_rd_data_data  = d;
            bus.s_mem_rd_data_last  = (k != 0);
            bus.m_rd_data_ready     = 2'b11;
            if (k == 0) begin
                bus.m_rd_data_ready = 2'b10;
                #1;
                n_checks++;
                if (bus.s_mem_rd_data_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL route_backpressure: got %b required 0", bus.s_mem_rd_data_ready);
                end
                bus.m_rd_data_ready = 2'b11;
            end
            #1;
            n_checks++;
            if (bus.m_rd_data_valid !== ((k < 2) ? 2'b01 : 2'b10) || bus.s_mem_rd_data_ready !== 1'b1 ||
                bus.m_rd_data_data !== d) begin
                n_fail++;
                $display("FAIL route_beat[%0d]: got valid %b ready %b data %h required %b 1 %h", k,
                         bus.m_rd_data_valid, bus.s_mem_rd_data_ready, bus.m_rd_data_data[63:0],
                         (k < 2) ? 2'b01 : 2'b10, d[63:0]);
            end
            $display("read beat %0d to valid %b", k, bus.m_rd_data_valid);
            tick();
        end
        bus.s_mem_rd_data_valid = 1'b0;
        bus.s_mem_rd_sts_valid = 1'b1;
        bus.m_rd_sts_ready     = 2'b11;
        for (int k = 0; k < 2; k++) begin
            bus.s_mem_rd_sts_data = 8'hA0 + 8'(k);
            #1;
            n_checks++;
            if (bus.m_rd_sts_valid !== ((k == 0) ? 2'b01 : 2'b10) || bus.m_rd_sts_data !== 8'hA0 + 8'(k)) begin
                n_fail++;
                $display("FAIL route_rd_sts[%0d]: got %b/%h required %b/%h", k, bus.m_rd_sts_valid,
                         bus.m_rd_sts_data, (k == 0) ? 2'b01 : 2'b10, 8'hA0 + 8'(k));
            end
            tick();
        end
        n_checks++;
        if (bus.m_rd_sts_valid !== 2'b00 || bus.s_mem_rd_sts_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL route_sts_drained: got %b/%b required 00/0", bus.m_rd_sts_valid, bus.s_mem_rd_sts_ready);
        end
        bus.s_mem_rd_sts_valid = 1'b0;
    endtask

    task automatic test_write_lock();
        logic [DATA_W-1:0] d;
        do_reset();
        bus.m_wr_cmd_ready = 1'b1;
        bus.m_mem_wr_data_ready = 1'b1;
        bus.s_wr_cmd_valid = 2'b10;
        bus.s_wr_cmd_addr  = {64'h300, 64'h400};
        #1;
        n_checks++;
        if (bus.s_wr_cmd_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_role_grant: got %b required 10", bus.s_wr_cmd_ready);
        end
        tick();
        n_checks++;
        if (bus.m_wr_cmd_valid !== 1'b1 || bus.m_wr_cmd_addr !== 64'h300) begin
            n_fail++;
            $display("FAIL wr_role_cmd: got %b/%h required 1/300", bus.m_wr_cmd_valid, bus.m_wr_cmd_addr);
        end
        bus.s_wr_cmd_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            d = {8{64'hB000_0000_0000_0000 + 64'(k)}};
            bus.s_wr_data_valid = 2'b11;
            bus.s_wr_data_data  = {d, {DATA_W{1'b1}}};
            bus.s_wr_data_last  = {(k == 3), 1'b0};
            #1;
            n_checks++;
            if (bus.s_wr_cmd_ready !== 2'b00 || bus.m_mem_wr_data_valid !== 1'b1 ||
                bus.s_wr_data_ready !== 2'b10 || bus.m_mem_wr_data_data !== d ||
                bus.m_mem_wr_data_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL wr_beat[%0d]: got cmd_rdy %b valid %b rdy %b last %b data %h required 00 1 10 %b %h",
                         k, bus.s_wr_cmd_ready, bus.m_mem_wr_data_valid, bus.s_wr_data_ready,
                         bus.m_mem_wr_data_last, bus.m_mem_wr_data_data[63:0], (k == 3), d[63:0]);
            end
            $display("write beat %0d from role", k);
            tick();
        end
        bus.s_wr_data_valid = 2'b00;
        #1;
        n_checks++;
        if (bus.s_wr_cmd_ready !== 2'b01 || bus.m_mem_wr_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_tcp_after_burst: got %b/%b required 01/0", bus.s_wr_cmd_ready, bus.m_mem_wr_data_valid);
        end
        tick();
        n_checks++;
        if (bus.m_wr_cmd_valid !== 1'b1 || bus.m_wr_cmd_addr !== 64'h400) begin
            n_fail++;
            $display("FAIL wr_tcp_cmd: got %b/%h required 1/400", bus.m_wr_cmd_valid, bus.m_wr_cmd_addr);
        end
        bus.s_wr_cmd_valid = 2'b00;
        bus.s_mem_wr_sts_valid = 1'b1;
        bus.s_mem_wr_sts_data  = 8'h5A;
        bus.m_wr_sts_ready     = 2'b11;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (bus.m_wr_sts_valid !== ((k == 0) ? 2'b10 : 2'b01) || bus.m_wr_sts_data !== 8'h5A) begin
                n_fail++;
                $display("FAIL wr_sts[%0d]: got %b/%h required %b/5a", k, bus.m_wr_sts_valid,
                         bus.m_wr_sts_data, (k == 0) ? 2'b10 : 2'b01);
            end
            tick();
        end
        bus.s_mem_wr_sts_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        bus.m_rd_cmd_ready = 1'b1;
        bus.s_rd_cmd_valid = 2'b01;
        for (int i = 0; i < 16; i++) begin
            bus.s_rd_cmd_addr[ADDR_W-1:0] = 64'(i);
            #1;
            n_checks++;
            if (bus.s_rd_cmd_ready !== 2'b01) begin
                n_fail++;
                $display("FAIL full_fill[%0d]: got %b required 01", i, bus.s_rd_cmd_ready);
            end
            tick();
        end
        bus.s_rd_cmd_addr[ADDR_W-1:0] = 64'hABCD;
        #1;
        n_checks++;
        if (bus.s_rd_cmd_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL full_stall: got %b required 00", bus.s_rd_cmd_ready);
        end
        tick();
        n_checks++;
        if (bus.s_rd_cmd_ready !== 2'b00 || bus.m_rd_cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall_hold: got %b/%b required 00/0", bus.s_rd_cmd_ready, bus.m_rd_cmd_valid);
        end
        bus.s_mem_rd_data_valid = 1'b1;
        bus.s_mem_rd_data_last  = 1'b1;
        bus.m_rd_data_ready     = 2'b01;
        #1;
        n_checks++;
        if (bus.s_mem_rd_data_ready !== 1'b1 || bus.s_rd_cmd_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL full_data_pop: got %b/%b required 1/00", bus.s_mem_rd_data_ready, bus.s_rd_cmd_ready);
        end
        tick();
        bus.s_mem_rd_data_valid = 1'b0;
        bus.s_mem_rd_sts_valid  = 1'b1;
        bus.m_rd_sts_ready      = 2'b01;
        #1;
        n_checks++;
        if (bus.s_rd_cmd_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL full_push_pop: got %b required 01", bus.s_rd_cmd_ready);
        end
        tick();
        bus.s_mem_rd_sts_valid = 1'b0;
        bus.s_rd_cmd_valid     = 2'b00;
        n_checks++;
        if (bus.m_rd_cmd_valid !== 1'b1 || bus.m_rd_cmd_addr !== 64'hABCD) begin
            n_fail++;
            $display("FAIL full_17th: got %b/%h required 1/abcd", bus.m_rd_cmd_valid, bus.m_rd_cmd_addr);
        end
        $display("17th read issued addr %h", bus.m_rd_cmd_addr);
    endtask

    task automatic test_empty_stall();
        do_reset();
        bus.s_mem_rd_data_valid = 1'b1;
        bus.s_mem_rd_data_last  = 1'b1;
        bus.m_rd_data_ready     = 2'b11;
        bus.s_mem_rd_sts_valid  = 1'b1;
        bus.m_rd_sts_ready      = 2'b11;
        #1;
        n_checks++;
        if (bus.s_mem_rd_data_ready !== 1'b0 || bus.m_rd_data_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL empty_data: got %b/%b required 0/00", bus.s_mem_rd_data_ready, bus.m_rd_data_valid);
        end
        n_checks++;
        if (bus.s_mem_rd_sts_ready !== 1'b0 || bus.m_rd_sts_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL empty_sts: got %b/%b required 0/00", bus.s_mem_rd_sts_ready, bus.m_rd_sts_valid);
        end
        tick();
        bus.s_mem_rd_sts_valid = 1'b0;
        bus.m_rd_cmd_ready = 1'b1;
        bus.s_rd_cmd_valid = 2'b01;
        #1;
        n_checks++;
        if (bus.s_rd_cmd_ready !== 2'b01 || bus.s_mem_rd_data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_same_cycle: got %b/%b required 01/0", bus.s_rd_cmd_ready, bus.s_mem_rd_data_ready);
        end
        tick();
        bus.s_rd_cmd_valid = 2'b00;
        #1;
        n_checks++;
        if (bus.s_mem_rd_data_ready !== 1'b1 || bus.m_rd_data_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL empty_released: got %b/%b required 1/01", bus.s_mem_rd_data_ready, bus.m_rd_data_valid);
        end
        tick();
        bus.s_mem_rd_data_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.m_rd_cmd_ready = 1'b1;
        bus.m_wr_cmd_ready = 1'b1;
        bus.m_mem_wr_data_ready = 1'b1;
        bus.s_rd_cmd_valid = 2'b01;
        bus.s_wr_cmd_valid = 2'b01;
        bus.s_wr_cmd_addr  = {64'h900, 64'h800};
        tick();
        bus.s_rd_cmd_valid = 2'b00;
        bus.s_wr_cmd_valid = 2'b00;
        bus.s_wr_data_valid = 2'b01;
        bus.s_wr_data_last  = 2'b00;
        #1;
        n_checks++;
        if (bus.m_mem_wr_data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_burst_active: got %b required 1", bus.m_mem_wr_data_valid);
        end
        tick();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.m_mem_wr_data_valid, bus.s_wr_data_ready, bus.m_wr_cmd_valid, bus.m_rd_cmd_valid} !== 5'b00000) begin
            n_fail++;
            $display("FAIL arst_outputs: got %b required 00000",
                     {bus.m_mem_wr_data_valid, bus.s_wr_data_ready, bus.m_wr_cmd_valid, bus.m_rd_cmd_valid});
        end
        clear_inputs();
        #1 rst_n = 1'b1;
        bus.m_rd_cmd_ready = 1'b1;
        bus.m_wr_cmd_ready = 1'b1;
        bus.s_rd_cmd_valid = 2'b11;
        bus.s_wr_cmd_valid = 2'b11;
        bus.s_wr_cmd_addr  = {64'h900, 64'h800};
        #1;
        n_checks++;
        if (bus.s_rd_cmd_ready !== 2'b01 || bus.s_wr_cmd_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL arst_prio: got rd %b wr %b required 01 01", bus.s_rd_cmd_ready, bus.s_wr_cmd_ready);
        end
        tick();
        n_checks++;
        if (bus.m_wr_cmd_addr !== 64'h800) begin
            n_fail++;
            $display("FAIL arst_first_wr: got %h required 800", bus.m_wr_cmd_addr);
        end
        $display("post-reset first grants to TCP");
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_round_robin();
        test_read_routing();
        test_write_lock();
        test_fifo_full();
        test_empty_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
